// File: rtl/frame_signature_rx.sv
// Pixel-stream sink: checks raster coordinates and {n,n} colour replication per frame,
// folds the 12-bit native colour into a rotating 16-bit signature and reports a per-frame summary.
module frame_signature_rx #(
   parameter int H_ACTIVE = 800,
   parameter int V_ACTIVE = 600
) (
   input  logic        pixel_clk,
   input  logic        sim_rst,
   input  logic [10:0] sdl_sx,
   input  logic [9:0]  sdl_sy,
   input  logic        sdl_de,
   input  logic [7:0]  sdl_r,
   input  logic [7:0]  sdl_g,
   input  logic [7:0]  sdl_b,
   output logic        frame_valid,
   output logic [15:0] frame_sig,
   output logic [19:0] frame_pix_cnt,
   output logic        frame_coord_err,
   output logic        frame_color_err,
   output logic [15:0] frame_cnt,
   output logic [7:0]  abort_cnt
);

   localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [15:0] sig_q, sig_d, sig_b_s;
   logic [19:0] pix_q, pix_d, pix_b_s;
   logic        cerr_q, cerr_d, cerr_b_s;
   logic        kerr_q, kerr_d, kerr_b_s;
   logic [10:0] ex_q, ex_d, ex_b_s;
   logic [9:0]  ey_q, ey_d, ey_b_s;
   logic        valid_q, valid_d;
   logic [15:0] fsig_q, fsig_d;
   logic [19:0] fpix_q, fpix_d;
   logic        fcerr_q, fcerr_d;
   logic        fkerr_q, fkerr_d;
   logic [15:0] fcnt_q, fcnt_d;
   logic [7:0]  abort_q, abort_d;
   logic        take_s, fresh_s, is_origin_s, is_last_s;
   logic [11:0] nib_s;

   function automatic logic color_bad(input logic [7:0] c);
      return c[7:4] != c[3:0];
   endfunction

   // Frame tracking: decide whether the sample is taken, then fold it into the accumulators.
   always_comb begin
      state_d     = state_q;
      sig_d       = sig_q;
      pix_d       = pix_q;
      cerr_d      = cerr_q;
      kerr_d      = kerr_q;
      ex_d        = ex_q;
      ey_d        = ey_q;
      valid_d     = 1'b0;
      fsig_d      = fsig_q;
      fpix_d      = fpix_q;
      fcerr_d     = fcerr_q;
      fkerr_d     = fkerr_q;
      fcnt_d      = fcnt_q;
      abort_d     = abort_q;
      take_s      = 1'b0;
      fresh_s     = 1'b0;
      is_origin_s = (sdl_sx == 11'd0) && (sdl_sy == 10'd0);
      is_last_s   = (sdl_sx == H_LAST) && (sdl_sy == V_LAST);
      nib_s       = {sdl_r[7:4], sdl_g[7:4], sdl_b[7:4]};

      case (state_q)
         IDLE: begin
            if (sdl_de && is_origin_s) begin
               take_s  = 1'b1;
               fresh_s = 1'b1;
            end else begin
               take_s  = 1'b0;
            end
         end
         ACTIVE: begin
            if (sdl_de) begin
               take_s = 1'b1;
               // An origin sample is only a restart when the raster did not predict it.
               if (is_origin_s && !((ex_q == 11'd0) && (ey_q == 10'd0))) begin
                  fresh_s = 1'b1;
                  abort_d = (abort_q == 8'hFF) ? abort_q : abort_q + 8'd1;
               end else begin
                  fresh_s = 1'b0;
               end
            end else begin
               take_s = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      sig_b_s  = fresh_s ? 16'h0000 : sig_q;
      pix_b_s  = fresh_s ? 20'd0 : pix_q;
      cerr_b_s = fresh_s ? 1'b0 : cerr_q;
      kerr_b_s = fresh_s ? 1'b0 : kerr_q;
      ex_b_s   = fresh_s ? 11'd0 : ex_q;
      ey_b_s   = fresh_s ? 10'd0 : ey_q;

      if (take_s) begin
         sig_d  = {sig_b_s[14:0], sig_b_s[15]} ^ {4'h0, nib_s};
         pix_d  = pix_b_s + 20'd1;
         cerr_d = cerr_b_s | color_bad(sdl_r) | color_bad(sdl_g) | color_bad(sdl_b);
         kerr_d = kerr_b_s | (sdl_sx != ex_b_s) | (sdl_sy != ey_b_s);
         if (sdl_sx == H_LAST) begin
            ex_d = 11'd0;
            ey_d = sdl_sy + 10'd1;
         end else begin
            ex_d = sdl_sx + 11'd1;
            ey_d = sdl_sy;
         end
         state_d = ACTIVE;
         if (is_last_s) begin
            fsig_d  = sig_d;
            fpix_d  = pix_d;
            fcerr_d = cerr_d;
            fkerr_d = kerr_d;
            fcnt_d  = fcnt_q + 16'd1;
            valid_d = 1'b1;
            state_d = IDLE;
         end else begin
            valid_d = 1'b0;
         end
      end else begin
         valid_d = 1'b0;
      end
   end

   // State, accumulator and summary registers.
   always_ff @(posedge pixel_clk or posedge sim_rst) begin
      if (sim_rst) begin
         state_q <= IDLE;
         sig_q   <= 16'h0000;
         pix_q   <= 20'd0;
         cerr_q  <= 1'b0;
         kerr_q  <= 1'b0;
         ex_q    <= 11'd0;
         ey_q    <= 10'd0;
         valid_q <= 1'b0;
         fsig_q  <= 16'h0000;
         fpix_q  <= 20'd0;
         fcerr_q <= 1'b0;
         fkerr_q <= 1'b0;
         fcnt_q  <= 16'd0;
         abort_q <= 8'd0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         pix_q   <= pix_d;
         cerr_q  <= cerr_d;
         kerr_q  <= kerr_d;
         ex_q    <= ex_d;
         ey_q    <= ey_d;
         valid_q <= valid_d;
         fsig_q  <= fsig_d;
         fpix_q  <= fpix_d;
         fcerr_q <= fcerr_d;
         fkerr_q <= fkerr_d;
         fcnt_q  <= fcnt_d;
         abort_q <= abort_d;
      end
   end

   assign frame_valid     = valid_q;
   assign frame_sig       = fsig_q;
   assign frame_pix_cnt   = fpix_q;
   assign frame_coord_err = fkerr_q;
   assign frame_color_err = fcerr_q;
   assign frame_cnt       = fcnt_q;
   assign abort_cnt       = abort_q;

endmodule

// File: tb/tb_frame_signature_rx.sv
// Self-checking bench for frame_signature_rx: table-driven frame scenarios, randomized frames
// against a behavioural reference model, reset mid-frame and frame counter wrap.
module tb_frame_signature_rx;

   localparam int H = 4;
   localparam int V = 3;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, de;
   logic [10:0] sx;
   logic [9:0]  sy;
   logic [7:0]  r, g, b;
   logic        frame_valid, frame_coord_err, frame_color_err;
   logic [15:0] frame_sig, frame_cnt;
   logic [19:0] frame_pix_cnt;
   logic [7:0]  abort_cnt;

   logic        w_rst, w_de;
   logic        w_valid, w_kerr, w_cerr;
   logic [15:0] w_sig, w_cnt;
   logic [19:0] w_pix;
   logic [7:0]  w_abort;

   frame_signature_rx #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .pixel_clk(clk), .sim_rst(rst), .sdl_sx(sx), .sdl_sy(sy), .sdl_de(de),
      .sdl_r(r), .sdl_g(g), .sdl_b(b),
      .frame_valid(frame_valid), .frame_sig(frame_sig), .frame_pix_cnt(frame_pix_cnt),
      .frame_coord_err(frame_coord_err), .frame_color_err(frame_color_err),
      .frame_cnt(frame_cnt), .abort_cnt(abort_cnt)
   );

   frame_signature_rx #(.H_ACTIVE(1), .V_ACTIVE(1)) u_wrap (
      .pixel_clk(clk), .sim_rst(w_rst), .sdl_sx(11'd0), .sdl_sy(10'd0), .sdl_de(w_de),
      .sdl_r(8'h00), .sdl_g(8'h00), .sdl_b(8'h11),
      .frame_valid(w_valid), .frame_sig(w_sig), .frame_pix_cnt(w_pix),
      .frame_coord_err(w_kerr), .frame_color_err(w_cerr),
      .frame_cnt(w_cnt), .abort_cnt(w_abort)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;

   // reference model: frame-in-progress accumulators and the expected visible outputs
   int m_in, m_sig, m_cnt, m_cerr, m_kerr, m_ex, m_ey;
   int e_valid, e_sig, e_pix, e_cerr, e_kerr, e_fcnt, e_abort;

   typedef struct {
      int kind;
      int sig;
      int pix;
      int cerr;
      int kerr;
      int abort_inc;
   } vec_t;
   vec_t tbl[5];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_in = 0; m_sig = 0; m_cnt = 0; m_cerr = 0; m_kerr = 0; m_ex = 0; m_ey = 0;
      e_valid = 0; e_sig = 0; e_pix = 0; e_cerr = 0; e_kerr = 0; e_fcnt = 0; e_abort = 0;
   endtask

   task automatic model_begin();
      m_sig = 0; m_cnt = 0; m_cerr = 0; m_kerr = 0; m_ex = 0; m_ey = 0;
   endtask

   task automatic model_sample(input bit d, input int x, input int y, input int cr, input int cg, input int cb);
      int nib;
      e_valid = 0;
      if (!d) return;
      if (m_in == 0) begin
         if (!(x == 0 && y == 0)) return;
         m_in = 1;
         model_begin();
      end else if (x == 0 && y == 0 && !(m_ex == 0 && m_ey == 0)) begin
         e_abort = (e_abort < 255) ? e_abort + 1 : 255;
         model_begin();
      end
      nib   = (cr / 16) * 256 + (cg / 16) * 16 + (cb / 16);
      m_sig = (((m_sig * 2) % 65536) + (m_sig / 32768)) ^ nib;
      m_cnt = (m_cnt + 1) % (1 << 20);
      if ((cr / 16 != cr % 16) || (cg / 16 != cg % 16) || (cb / 16 != cb % 16)) m_cerr = 1;
      if (x != m_ex || y != m_ey) m_kerr = 1;
      if (x == H - 1) begin
         m_ex = 0;
         m_ey = (y + 1) % 1024;
      end else begin
         m_ex = x + 1;
         m_ey = y;
      end
      if (x == H - 1 && y == V - 1) begin
         e_valid = 1; e_sig = m_sig; e_pix = m_cnt; e_cerr = m_cerr; e_kerr = m_kerr;
         e_fcnt  = (e_fcnt + 1) % 65536;
         m_in    = 0;
      end
   endtask

   // one cycle: check what the previous sample produced, then drive and model the next one
   task automatic step(input bit d, input int x, input int y, input int cr, input int cg, input int cb);
      @(negedge clk);
      chk("frame_valid", frame_valid, e_valid);
      chk("frame_sig", frame_sig, e_sig);
      chk("frame_pix_cnt", frame_pix_cnt, e_pix);
      chk("frame_color_err", frame_color_err, e_cerr);
      chk("frame_coord_err", frame_coord_err, e_kerr);
      chk("frame_cnt", frame_cnt, e_fcnt);
      chk("abort_cnt", abort_cnt, e_abort);
      if (frame_valid) pulses++;
      de = d; sx = 11'(x); sy = 10'(y); r = 8'(cr); g = 8'(cg); b = 8'(cb);
      model_sample(d, x, y, cr, cg, cb);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0);
   endtask

   task automatic send_frame(input int kind);
      int cr;
      if (kind == 4) begin
         for (int k = 0; k < 5; k++) step(1'b1, k % H, k / H, 8'h00, 8'h00, 8'h11);
      end
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            cr = (kind == 2 && x == 2 && y == 1) ? 8'h12 : 8'h00;
            if (!(kind == 3 && x == 1 && y == 1)) begin
               step(1'b1, x, y, cr, 8'h00, 8'h11);
               if (kind == 1 && x < H - 1) idle($urandom_range(1, 3));
            end
         end
         if (kind == 1 && y < V - 1) idle(5);
      end
      idle(2);
   endtask

   task automatic random_frame();
      int k, restarts, x, y, cr, cg, cb;
      if ($urandom_range(0, 4) == 0) step(1'b1, $urandom_range(1, H - 1), $urandom_range(0, V - 1), 8'h33, 8'h44, 8'h55);
      k = 0;
      restarts = 0;
      while (k < H * V) begin
         x = k % H;
         y = k / H;
         cr = $urandom_range(0, 15) * 17;
         cg = $urandom_range(0, 15) * 17;
         cb = $urandom_range(0, 15) * 17;
         if ($urandom_range(0, 19) == 0) cr = $urandom_range(0, 255);
         if ($urandom_range(0, 29) == 0) x = $urandom_range(0, H - 1);
         if ($urandom_range(0, 24) != 0) step(1'b1, x, y, cr, cg, cb);
         idle($urandom_range(0, 2));
         if (restarts < 2 && k > 0 && $urandom_range(0, 14) == 0) begin
            restarts++;
            k = 0;
         end else begin
            k++;
         end
      end
      idle(2);
   endtask

   initial begin
      int fc_exp, ab_exp;
      tbl[0] = '{kind: 0, sig: 16'h0FFF, pix: 12, cerr: 0, kerr: 0, abort_inc: 0};
      tbl[1] = '{kind: 1, sig: 16'h0FFF, pix: 12, cerr: 0, kerr: 0, abort_inc: 0};
      tbl[2] = '{kind: 2, sig: 16'h2FFF, pix: 12, cerr: 1, kerr: 0, abort_inc: 0};
      tbl[3] = '{kind: 3, sig: 16'h07FF, pix: 11, cerr: 0, kerr: 1, abort_inc: 0};
      tbl[4] = '{kind: 4, sig: 16'h0FFF, pix: 12, cerr: 0, kerr: 0, abort_inc: 1};

      rst = 1'b1; w_rst = 1'b1; w_de = 1'b0;
      de = 1'b0; sx = 11'd0; sy = 10'd0; r = 8'h00; g = 8'h00; b = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset frame_valid", frame_valid, 0);
      chk("reset frame_sig", frame_sig, 0);
      chk("reset frame_pix_cnt", frame_pix_cnt, 0);
      chk("reset frame_cnt", frame_cnt, 0);
      chk("reset abort_cnt", abort_cnt, 0);
      rst = 1'b0;

      fc_exp = 0;
      ab_exp = 0;
      for (int i = 0; i < 5; i++) begin
         pulses = 0;
         send_frame(tbl[i].kind);
         fc_exp++;
         ab_exp += tbl[i].abort_inc;
         chk($sformatf("tbl%0d pulses", i), pulses, 1);
         chk($sformatf("tbl%0d sig", i), frame_sig, tbl[i].sig);
         chk($sformatf("tbl%0d pix", i), frame_pix_cnt, tbl[i].pix);
         chk($sformatf("tbl%0d color_err", i), frame_color_err, tbl[i].cerr);
         chk($sformatf("tbl%0d coord_err", i), frame_coord_err, tbl[i].kerr);
         chk($sformatf("tbl%0d frame_cnt", i), frame_cnt, fc_exp);
         chk($sformatf("tbl%0d abort_cnt", i), abort_cnt, ab_exp);
      end

      // back-to-back frames: next origin right after the last pixel
      pulses = 0;
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < H * V; k++) step(1'b1, k % H, k / H, 8'h00, 8'h00, 8'h11);
      idle(2);
      chk("b2b pulses", pulses, 2);
      chk("b2b frame_cnt", frame_cnt, fc_exp + 2);

      // reset mid-frame
      for (int k = 0; k < 6; k++) step(1'b1, k % H, k / H, 8'h00, 8'h00, 8'h11);
      @(negedge clk);
      rst = 1'b1; de = 1'b0;
      @(negedge clk);
      chk("midrst frame_valid", frame_valid, 0);
      chk("midrst frame_sig", frame_sig, 0);
      chk("midrst frame_cnt", frame_cnt, 0);
      chk("midrst abort_cnt", abort_cnt, 0);
      rst = 1'b0;
      model_reset();
      pulses = 0;
      send_frame(0);
      chk("postrst pulses", pulses, 1);
      chk("postrst frame_cnt", frame_cnt, 1);
      chk("postrst abort_cnt", abort_cnt, 0);
      chk("postrst sig", frame_sig, 16'h0FFF);

      for (int f = 0; f < 40; f++) random_frame();

      // frame counter wrap with a 1x1 geometry: every origin sample completes a frame
      @(negedge clk);
      w_rst = 1'b0;
      w_de  = 1'b1;
      repeat (65535) @(negedge clk);
      chk("wrap frame_cnt ffff", w_cnt, 16'hFFFF);
      @(negedge clk);
      w_de = 1'b0;
      chk("wrap frame_cnt 0", w_cnt, 0);
      chk("wrap frame_valid", w_valid, 1);
      chk("wrap abort_cnt", w_abort, 0);
      @(negedge clk);
      chk("wrap pulse ends", w_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
